// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned memory requests and
// buffers returned words for decode. Optional macro FETCH_ALIGN_CHECK_EN adds misalign_err.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [6:0]        opcode
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef enum logic [0:0] {FETCH, DRAIN} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc, pc_next;
  logic [CNT_W-1:0]    outstanding, out_next;
  logic [CNT_W-1:0]    discard, discard_next;
  logic [CNT_W-1:0]    occ, occ_next;
  logic                req_valid_next;

  logic [31:0]         data_mem [DEPTH];
  logic [ADDR_W-1:0]   ipc_mem  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  logic [ADDR_W-1:0]   pcq_mem  [DEPTH];
  logic [PTR_W-1:0]    pcq_wr, pcq_rd;

  logic                fire, push, pop;
  logic [CNT_W:0]      credit_sum;

  assign imem_req_addr = pc;
  assign instr_valid   = (occ != '0);
  assign instr         = data_mem[rd_ptr];
  assign instr_pc      = ipc_mem[rd_ptr];
  assign opcode        = data_mem[rd_ptr][6:0];

  // Redirect dominates: the pop is ignored and a same-cycle response is always dropped.
  always_comb begin
    fire         = imem_req_valid && imem_req_ready;
    push         = imem_rsp_valid && (discard == '0) && !redirect_valid;
    pop          = instr_valid && instr_ready && !redirect_valid;
    out_next     = outstanding + CNT_W'(fire) - CNT_W'(imem_rsp_valid);
    occ_next     = redirect_valid ? '0 : (occ + CNT_W'(push) - CNT_W'(pop));
    discard_next = discard;
    if (redirect_valid)
      discard_next = out_next;
    else if (imem_rsp_valid && (discard != '0))
      discard_next = discard - CNT_W'(1);
    state_next = state;
    if (redirect_valid)
      state_next = (out_next != '0) ? DRAIN : FETCH;
    else if ((state == DRAIN) && (discard_next == '0))
      state_next = FETCH;
    pc_next = pc;
    if (redirect_valid)
      pc_next = redirect_pc & ~ADDR_W'(3);
    else if (fire)
      pc_next = pc + ADDR_W'(4);
    credit_sum     = {1'b0, occ_next} + {1'b0, out_next};
    req_valid_next = (state_next == FETCH) && (credit_sum < DEPTH_W);
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      outstanding    <= '0;
      discard        <= '0;
      occ            <= '0;
      imem_req_valid <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pcq_wr         <= '0;
      pcq_rd         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        ipc_mem[i]  <= '0;
        pcq_mem[i]  <= '0;
      end
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      outstanding    <= out_next;
      discard        <= discard_next;
      occ            <= occ_next;
      imem_req_valid <= req_valid_next;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        pcq_wr <= '0;
        pcq_rd <= '0;
      end else begin
        if (fire) begin
          pcq_mem[pcq_wr] <= pc;
          pcq_wr          <= pcq_wr + PTR_W'(1);
        end
        if (push) begin
          data_mem[wr_ptr] <= imem_rsp_data;
          ipc_mem[wr_ptr]  <= pcq_mem[pcq_rd];
          wr_ptr           <= wr_ptr + PTR_W'(1);
          pcq_rd           <= pcq_rd + PTR_W'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky until reset so software can inspect it long after the bad branch.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)
      misalign_err <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      misalign_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a
// queue-based model of requests in flight and buffered instructions.
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode)
`ifdef FETCH_ALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    bit          drop;
    int          due;
  } req_t;

  req_t        inflight[$];
  logic [31:0] fifo_q[$];
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_mis;
  int          cyc;
  int          checks;
  int          errors;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_CAFE;
  endfunction

  function automatic bit draining();
    foreach (inflight[i]) if (inflight[i].drop) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit expReqValid();
    return m_started && !draining() && ((fifo_q.size() + inflight.size()) < DEPTH);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle();
    bit v;
    logic [31:0] hp;
    v = expReqValid();
    checkOutput("req_valid", {31'b0, imem_req_valid}, {31'b0, v});
    if (v) checkOutput("req_addr", imem_req_addr, m_pc);
    checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, fifo_q.size() != 0});
    if (fifo_q.size() != 0) begin
      hp = fifo_q[0];
      checkOutput("instr_pc", instr_pc, hp);
      checkOutput("instr", instr, memWord(hp));
      checkOutput("opcode", {25'b0, opcode}, {25'b0, memWord(hp) & 32'h7F});
    end
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
`endif
  endtask

  // Drives one cycle of inputs, advances the model to match the coming edge.
  task automatic applyStimulus(input bit rq_rdy, input bit in_rdy, input bit redir,
                               input logic [31:0] tgt, input int lat);
    bit   fire, rsp, pop;
    req_t e;
    fire = expReqValid() && rq_rdy;
    rsp  = (inflight.size() != 0) && (inflight[0].due <= cyc);
    pop  = (fifo_q.size() != 0) && in_rdy;
    imem_req_ready = rq_rdy;
    instr_ready    = in_rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memWord(inflight[0].pc) : $urandom;
    if (pop && !redir) void'(fifo_q.pop_front());
    if (rsp) begin
      e = inflight.pop_front();
      if (!e.drop && !redir) fifo_q.push_back(e.pc);
    end
    if (fire) begin
      e.pc   = m_pc;
      e.drop = 1'b0;
      e.due  = cyc + lat;
      if (inflight.size() != 0 && e.due <= inflight[$].due) e.due = inflight[$].due + 1;
      inflight.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      fifo_q.delete();
      foreach (inflight[i]) inflight[i].drop = 1'b1;
      m_pc = tgt & ~32'd3;
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
    end
    m_started = 1'b1;
    @(posedge clk);
    cyc++;
  endtask

  task automatic step(input bit rq_rdy, input bit in_rdy, input bit redir,
                      input logic [31:0] tgt, input int lat);
    checkCycle();
    applyStimulus(rq_rdy, in_rdy, redir, tgt, lat);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset_n        = 1'b1;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rst_req_addr", imem_req_addr, 32'h0);
    checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
    checkOutput("rst_opcode", {25'b0, opcode}, 32'h0);
    inflight.delete();
    fifo_q.delete();
    m_pc      = 32'h0;
    m_started = 1'b0;
    m_mis     = 1'b0;
    reset_n   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;

    // Streaming at latency 1 with everything ready.
    doReset();
    repeat (10) step(1, 1, 0, 32'h0, 1);

    // Back-pressure from decode fills the buffer, then releases.
    doReset();
    repeat (8) step(1, 0, 0, 32'h0, 1);
    checkOutput("full_head_pc", instr_pc, 32'h0);
    repeat (6) step(1, 1, 0, 32'h0, 1);

    // Memory not ready: request must hold its address.
    doReset();
    step(0, 1, 0, 32'h0, 1);
    repeat (3) begin
      checkOutput("held_addr", imem_req_addr, 32'h0);
      step(0, 1, 0, 32'h0, 1);
    end
    repeat (6) step(1, 1, 0, 32'h0, 1);

    // Redirect at latency 3 with two requests in flight.
    doReset();
    repeat (3) step(1, 1, 0, 32'h0, 3);
    step(1, 1, 1, 32'h100, 3);
    repeat (12) step(1, 1, 0, 32'h0, 3);

    // Redirect colliding with a response and a pop; misaligned target.
    doReset();
    repeat (3) step(1, 1, 0, 32'h0, 1);
    step(1, 1, 1, 32'h102, 1);
    checkOutput("redir_instr_valid", {31'b0, instr_valid}, 32'd0);
    repeat (8) step(1, 1, 0, 32'h0, 1);

    // Random traffic.
    doReset();
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tgt;
      bit          rd;
      rd  = ($urandom_range(0, 24) == 0) && (i > 0);
      tgt = {20'h0, 12'($urandom_range(0, 4095))};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rd, tgt,
           $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle control decoder.
- Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO and presents them, with their PC and decoded 7-bit opcode field, to the decode/control stage via valid/ready.
- Handles redirects (taken branch) by flushing the FIFO and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC/address width.
- DEPTH, 2, FIFO entries; also the maximum number of outstanding requests (power of two, 2..8).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-high reset (1 = reset asserted).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  request address, bits[1:0] always 0.
- imem_rsp_valid  in  1  response word valid, in request order, latency >= 1 cycle.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch taken, one-cycle pulse.
- redirect_pc  in  ADDR_W  branch target.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  consumer accepts head.
- instr  out  32  head instruction.
- instr_pc  out  ADDR_W  PC of head instruction.
- opcode  out  7  instr[6:0], feeds control decoder.

Behaviour:
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, opcode=0.
  - FIFO empty, outstanding=0, discard=0, state=FETCH.
- Reset mid-transaction aborts everything. Responses arriving after reset deasserts for pre-reset requests are the memory's responsibility; the memory is reset alongside this block.
- Credit: imem_req_valid=1 in FETCH when occupancy+outstanding < DEPTH.
- Request handshake:
  - A request fires when imem_req_valid and imem_req_ready are both 1.
  - On fire: outstanding+1, pc+4.
  - Once asserted, valid and addr are held stable until fire. The only exception is a redirect, which withdraws the pending request.
- pc wraps modulo 2^ADDR_W.
- Response handling:
  - imem_rsp_valid with discard>0: word dropped, discard-1, outstanding-1.
  - Otherwise: push {data, pc_of_request}, outstanding-1.
  - Request PCs are tracked in a DEPTH-entry PC queue pushed at fire.
- Output FIFO:
  - instr/instr_pc/opcode are combinational from the head.
  - A pop occurs when instr_valid and instr_ready are both 1.
  - Push and pop in the same cycle are allowed at any occupancy.
  - Credit guarantees no push into a full FIFO.
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO and PC queue flushed; pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - discard <= outstanding after this cycle's fire/response updates. A request firing in the redirect cycle is counted; a response in the redirect cycle is dropped.
  - A pop in the same cycle is ignored.
  - instr_valid=0 the next cycle.
- FSM:
  - FETCH -> DRAIN on redirect with post-update outstanding>0.
  - FETCH stays FETCH on redirect with outstanding==0; the new request is valid the next cycle.
  - DRAIN: imem_req_valid=0. Goes DRAIN -> FETCH when discard reaches 0.
  - Redirect in DRAIN: reload pc, discard = outstanding, stay DRAIN.
- Latency: first request valid the cycle after reset deasserts. Response to instr_valid takes 1 cycle (registered push, combinational head).

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Extra output misalign_err (1 bit, reset 0).
  - Set sticky when redirect_valid=1 and redirect_pc[1:0]!=0; cleared only by reset.
  - The PC is still forced to word alignment.
- Undefined: no port; misaligned targets are silently aligned.

Test Plan:
- Reset, memory latency 1, ready=1, instr_ready=1 -> requests to 0x0, 0x4, 0x8 on consecutive cycles; instr_pc sequence 0x0, 0x4, 0x8; opcode equals rsp_data[6:0].
- instr_ready=0, DEPTH=2 -> exactly 2 requests fire, then imem_req_valid stays 0; FIFO holds 0x0, 0x4. Releasing instr_ready resumes at 0x8.
- imem_req_ready=0 for 3 cycles -> imem_req_valid=1 with addr 0x0 held stable all 3 cycles; fire on the 4th.
- Latency 3, redirect to 0x100 with 2 outstanding -> both late responses dropped, no instr_valid for them; next request addr 0x100; instr_pc=0x100 first.
- Redirect in the same cycle as rsp_valid and instr pop -> response dropped, FIFO empty next cycle, pc=target.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> imem_req_addr 0x100, misalign_err=1 and stays 1 until reset.
